// File: rtl/mem_ctrl_if.sv
// CPU-side bus of the memory controller: one read-only IF port and one
// read/write MEM port, both using the request/busy/done protocol.
//
// Handshake: a requester raises *_re (or mem_we) and holds it, together with
// its address/wdata/sel, until it sees a one-cycle *_done pulse. The
// controller samples requests only while idle. *_busy is high whenever the
// controller is occupied on behalf of either port. *_data is valid in the
// *_done cycle and holds until that port's next read completes.
interface mem_ctrl_if;
  logic        if_re;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_busy;
  logic        if_done;

  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_data;
  logic        mem_busy;
  logic        mem_done;

  // Pipeline side: issues requests, consumes results.
  modport master (
    output if_re, if_addr, mem_re, mem_we, mem_addr, mem_wdata, mem_sel,
    input  if_data, if_busy, if_done, mem_data, mem_busy, mem_done
  );

  // Controller side: accepts requests, produces results.
  modport slave (
    input  if_re, if_addr, mem_re, mem_we, mem_addr, mem_wdata, mem_sel,
    output if_data, if_busy, if_done, mem_data, mem_busy, mem_done
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: turns 32-bit little-endian word accesses from the IF
// and MEM ports into four byte cycles on an 8-bit synchronous RAM.
// MEM has priority over IF; a write wins over a read on the MEM port.
// All outputs are registered so there is no input-to-output combinational path.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_ctrl_if.slave         bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic              owner_mem_q, owner_mem_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic [23:0]       word_q, word_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              if_busy_q, if_busy_d;
  logic              mem_busy_q, mem_busy_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;

  // Byte index and address of the next byte cycle; wraps modulo 2^ADDR_W.
  logic [1:0]        k_nx;
  logic [ADDR_W-1:0] addr_nx;
  assign k_nx    = k_q[1:0] + 2'd1;
  assign addr_nx = base_q + ADDR_W'(k_nx);

  // Only the low ADDR_W address bits reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W], bus.mem_addr[31:ADDR_W]};

  // State and datapath registers; reset abandons any access and zeroes outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      owner_mem_q <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      word_q      <= '0;
      if_data_q   <= '0;
      mem_data_q  <= '0;
      if_busy_q   <= 1'b0;
      mem_busy_q  <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      owner_mem_q <= owner_mem_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      word_q      <= word_d;
      if_data_q   <= if_data_d;
      mem_data_q  <= mem_data_d;
      if_busy_q   <= if_busy_d;
      mem_busy_q  <= mem_busy_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Next state, byte sequencing and the registered values of every output.
  // RAM signals are computed one cycle ahead so that byte k appears in the
  // cycle where the counter equals k.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    owner_mem_d = owner_mem_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    word_d      = word_q;
    if_data_d   = if_data_q;
    mem_data_d  = mem_data_q;
    if_busy_d   = if_busy_q;
    mem_busy_d  = mem_busy_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;

    unique case (state_q)
      IDLE: begin
        if_busy_d  = 1'b0;
        mem_busy_d = 1'b0;
        if (bus.mem_we || bus.mem_re || bus.if_re) begin
          k_d        = '0;
          if_busy_d  = 1'b1;
          mem_busy_d = 1'b1;
          wdata_d    = bus.mem_wdata;
          sel_d      = bus.mem_sel;
          if (bus.mem_we || bus.mem_re) begin
            owner_mem_d = 1'b1;
            base_d      = bus.mem_addr[ADDR_W-1:0];
          end else begin
            owner_mem_d = 1'b0;
            base_d      = bus.if_addr[ADDR_W-1:0];
          end
          ram_addr_d = base_d;
          if (bus.mem_we) begin
            state_d     = WRITE;
            ram_we_d    = bus.mem_sel[0];
            ram_wdata_d = bus.mem_wdata[7:0];
          end else begin
            state_d = READ;
          end
        end
      end

      READ: begin
        k_d = k_q + 3'd1;
        if (k_q < 3'd3) begin
          ram_addr_d = addr_nx;
        end
        // Read data lags the address by one cycle, so byte k-1 arrives at k.
        case (k_q)
          3'd1:    word_d[7:0]   = ram_rdata;
          3'd2:    word_d[15:8]  = ram_rdata;
          3'd3:    word_d[23:16] = ram_rdata;
          default: word_d        = word_q;
        endcase
        if (k_q == 3'd4) begin
          state_d    = DONE;
          k_d        = '0;
          if_done_d  = !owner_mem_q;
          mem_done_d = owner_mem_q;
          if_busy_d  = owner_mem_q;
          mem_busy_d = !owner_mem_q;
          if (owner_mem_q) begin
            mem_data_d = {ram_rdata, word_q};
          end else begin
            if_data_d = {ram_rdata, word_q};
          end
        end
      end

      WRITE: begin
        k_d = k_q + 3'd1;
        if (k_q < 3'd3) begin
          ram_addr_d  = addr_nx;
          ram_wdata_d = wdata_q[8*k_nx +: 8];
          ram_we_d    = sel_q[k_nx];
        end else begin
          state_d    = DONE;
          k_d        = '0;
          if_done_d  = !owner_mem_q;
          mem_done_d = owner_mem_q;
          if_busy_d  = owner_mem_q;
          mem_busy_d = !owner_mem_q;
        end
      end

      DONE: begin
        state_d    = IDLE;
        if_busy_d  = 1'b0;
        mem_busy_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.if_data  = if_data_q;
  assign bus.if_busy  = if_busy_q;
  assign bus.if_done  = if_done_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_busy = mem_busy_q;
  assign bus.mem_done = mem_done_q;
  assign ram_addr     = ram_addr_q;
  assign ram_we       = ram_we_q;
  assign ram_wdata    = ram_wdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed accesses against a behavioural byte RAM.
// Expected read words are queued when a request is issued; a monitor pops
// and compares them whenever a done pulse appears. Directed observations
// (latencies, busy, RAM contents, reset values) go through a probe queue
// that the same monitor drains, so all counting lives in one process.
module tb_mem_ctrl;
  localparam int ADDR_W = 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  mem_ctrl_if bus();
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic [1:0]        dbg_state;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- RAM model with backdoor preload ----------------
  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [7:0]        bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [127:0] name;
    logic [31:0]  act;
    logic [31:0]  exp;
  } probe_t;

  logic [31:0] if_exp_q[$];
  logic [31:0] mem_exp_q[$];
  probe_t      probe_q[$];
  bit          tb_done = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  initial begin : monitor
    probe_t      p;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        n_cmp++;
        if (p.act !== p.exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", p.name, p.act, p.exp);
        end
      end
      if (bus.if_done === 1'b1) begin
        n_cmp++;
        if (if_exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL if_data: unexpected if_done, got %h expected none", bus.if_data);
        end else begin
          e = if_exp_q.pop_front();
          if (bus.if_data !== e) begin
            n_bad++;
            $display("FAIL if_data: got %h expected %h", bus.if_data, e);
          end
        end
      end
      if (bus.mem_done === 1'b1) begin
        n_cmp++;
        if (mem_exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL mem_data: unexpected mem_done, got %h expected none", bus.mem_data);
        end else begin
          e = mem_exp_q.pop_front();
          if (bus.mem_data !== e) begin
            n_bad++;
            $display("FAIL mem_data: got %h expected %h", bus.mem_data, e);
          end
        end
      end
      if (tb_done) begin
        n_cmp++;
        if (if_exp_q.size() + mem_exp_q.size() != 0) begin
          n_bad++;
          $display("FAIL pending: got %0d outstanding done pulses expected 0",
                   if_exp_q.size() + mem_exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [ADDR_W-1:0] addr_log [4];

  task automatic probe(input logic [127:0] nm, input logic [31:0] a, input logic [31:0] e);
    probe_t p;
    p.name = nm;
    p.act  = a;
    p.exp  = e;
    probe_q.push_back(p);
  endtask

  task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge clk); #1;
    bd_we   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for the selected done pulse; cyc stays 0 on timeout.
  // Logs the first four RAM addresses, counts write strobes, checks that
  // both busy lines stay high before done and that the port's data holds.
  task automatic wait_done(input bit on_mem, input bit chk_busy, output int cyc,
                           output bit busy_ok, output int we_cnt, output bit stable);
    logic [31:0] d0;
    d0      = on_mem ? bus.mem_data : bus.if_data;
    cyc     = 0;
    busy_ok = 1'b1;
    we_cnt  = 0;
    stable  = 1'b1;
    for (int c = 1; c <= 40 && cyc == 0; c++) begin
      step();
      if (c <= 4) addr_log[c-1] = ram_addr;
      if (ram_we) we_cnt++;
      if (on_mem ? bus.mem_done : bus.if_done) begin
        cyc = c;
      end else begin
        if (chk_busy && !(bus.if_busy && bus.mem_busy)) busy_ok = 1'b0;
        if ((on_mem ? bus.mem_data : bus.if_data) !== d0) stable = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    int cyc, cyc2, we_cnt, dones;
    bit busy_ok, stable;

    bus.if_re     = 1'b0;
    bus.if_addr   = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_sel   = '0;

    // Preload while the DUT is held in reset.
    bd_write(17'h00100, 8'h13); bd_write(17'h00101, 8'h05);
    bd_write(17'h00102, 8'h10); bd_write(17'h00103, 8'h00);
    bd_write(17'h00000, 8'h78); bd_write(17'h00001, 8'h56);
    bd_write(17'h00002, 8'h34); bd_write(17'h00003, 8'h12);
    bd_write(17'h00200, 8'h01); bd_write(17'h00201, 8'h02);
    bd_write(17'h00202, 8'h03); bd_write(17'h00203, 8'h04);
    bd_write(17'h1FFFE, 8'h9A); bd_write(17'h1FFFF, 8'hBC);
    bd_write(17'h00300, 8'hAA); bd_write(17'h00301, 8'hAA);
    bd_write(17'h00302, 8'hAA); bd_write(17'h00303, 8'hAA);

    // Reset values.
    probe("rst_if_data", bus.if_data, 32'h0);
    probe("rst_mem_data", bus.mem_data, 32'h0);
    probe("rst_busy", 32'({bus.if_busy, bus.mem_busy}), 32'h0);
    probe("rst_done", 32'({bus.if_done, bus.mem_done}), 32'h0);
    probe("rst_ram_we", 32'(ram_we), 32'h0);
    probe("rst_ram_addr", 32'(ram_addr), 32'h0);
    probe("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    probe("rst_state", 32'(dbg_state), 32'h0);
    rst_n = 1'b1;
    step();

    // 1: IF read of 0x100.
    bus.if_addr = 32'h0000_0100;
    bus.if_re   = 1'b1;
    if_exp_q.push_back(32'h0010_0513);
    wait_done(1'b0, 1'b1, cyc, busy_ok, we_cnt, stable);
    bus.if_re = 1'b0;
    probe("t1_latency", 32'(cyc), 32'd6);
    probe("t1_busy", 32'(busy_ok), 32'd1);
    probe("t1_busy_done", 32'({bus.if_busy, bus.mem_busy}), 32'b01);
    probe("t1_no_we", 32'(we_cnt), 32'd0);
    step();
    probe("t1_pulse", 32'({bus.if_done, bus.mem_done}), 32'h0);

    // 2: simultaneous IF read 0x0 and MEM write 0x200 (sel 0011).
    bus.if_addr   = 32'h0000_0000;
    bus.if_re     = 1'b1;
    bus.mem_addr  = 32'h0000_0200;
    bus.mem_wdata = 32'hDEAD_BEEF;
    bus.mem_sel   = 4'b0011;
    bus.mem_we    = 1'b1;
    mem_exp_q.push_back(32'h0);
    if_exp_q.push_back(32'h1234_5678);
    wait_done(1'b1, 1'b1, cyc, busy_ok, we_cnt, stable);
    bus.mem_we = 1'b0;
    probe("t2_mem_latency", 32'(cyc), 32'd5);
    probe("t2_busy", 32'(busy_ok), 32'd1);
    probe("t2_busy_done", 32'({bus.if_busy, bus.mem_busy}), 32'b10);
    probe("t2_we_count", 32'(we_cnt), 32'd2);
    wait_done(1'b0, 1'b0, cyc2, busy_ok, we_cnt, stable);
    bus.if_re = 1'b0;
    probe("t2_if_latency", 32'(cyc + cyc2), 32'd12);
    probe("t2_ram200", 32'(ram[17'h00200]), 32'hEF);
    probe("t2_ram201", 32'(ram[17'h00201]), 32'hBE);
    probe("t2_ram202", 32'(ram[17'h00202]), 32'h03);
    probe("t2_ram203", 32'(ram[17'h00203]), 32'h04);
    step();

    // 3: MEM read wrapping past the top of the RAM; upper address bits ignored.
    bus.mem_addr = 32'hABC1_FFFE;
    bus.mem_re   = 1'b1;
    mem_exp_q.push_back(32'h5678_BC9A);
    wait_done(1'b1, 1'b1, cyc, busy_ok, we_cnt, stable);
    bus.mem_re = 1'b0;
    probe("t3_latency", 32'(cyc), 32'd6);
    probe("t3_addr0", 32'(addr_log[0]), 32'h1FFFE);
    probe("t3_addr1", 32'(addr_log[1]), 32'h1FFFF);
    probe("t3_addr2", 32'(addr_log[2]), 32'h00000);
    probe("t3_addr3", 32'(addr_log[3]), 32'h00001);
    probe("t3_no_we", 32'(we_cnt), 32'd0);
    step();

    // 4: reset in the middle of a write (k=1).
    bus.mem_addr  = 32'h0000_0300;
    bus.mem_wdata = 32'h4433_2211;
    bus.mem_sel   = 4'b1111;
    bus.mem_we    = 1'b1;
    step();
    step();
    probe("t4_we_k1", 32'(ram_we), 32'd1);
    probe("t4_addr_k1", 32'(ram_addr), 32'h00301);
    rst_n = 1'b0;
    #1;
    probe("t4_rst_we", 32'(ram_we), 32'd0);
    probe("t4_rst_addr", 32'(ram_addr), 32'h0);
    probe("t4_rst_busy", 32'({bus.if_busy, bus.mem_busy}), 32'h0);
    probe("t4_rst_mem_data", bus.mem_data, 32'h0);
    probe("t4_rst_if_data", bus.if_data, 32'h0);
    bus.mem_we = 1'b0;
    step();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.mem_done || bus.if_done) dones++;
    end
    probe("t4_no_done", 32'(dones), 32'd0);
    probe("t4_state", 32'(dbg_state), 32'h0);
    probe("t4_ram300", 32'(ram[17'h00300]), 32'h11);
    probe("t4_ram302", 32'(ram[17'h00302]), 32'hAA);
    probe("t4_ram303", 32'(ram[17'h00303]), 32'hAA);

    // 5: mem_re and mem_we together -> write.
    bus.mem_addr  = 32'h0000_0400;
    bus.mem_wdata = 32'h8765_4321;
    bus.mem_sel   = 4'b1111;
    bus.mem_re    = 1'b1;
    bus.mem_we    = 1'b1;
    mem_exp_q.push_back(32'h0);
    wait_done(1'b1, 1'b1, cyc, busy_ok, we_cnt, stable);
    bus.mem_re = 1'b0;
    bus.mem_we = 1'b0;
    probe("t5_latency", 32'(cyc), 32'd5);
    probe("t5_we_count", 32'(we_cnt), 32'd4);
    step();
    probe("t5_ram_word", {ram[17'h00403], ram[17'h00402], ram[17'h00401], ram[17'h00400]},
          32'h8765_4321);

    // 6: IF read held across two accesses.
    bus.if_addr = 32'h0000_0100;
    bus.if_re   = 1'b1;
    if_exp_q.push_back(32'h0010_0513);
    if_exp_q.push_back(32'h0010_0513);
    wait_done(1'b0, 1'b1, cyc, busy_ok, we_cnt, stable);
    probe("t6_first", 32'(cyc), 32'd6);
    wait_done(1'b0, 1'b0, cyc2, busy_ok, we_cnt, stable);
    bus.if_re = 1'b0;
    probe("t6_spacing", 32'(cyc2), 32'd7);
    probe("t6_data_hold", 32'(stable), 32'd1);
    step();
    step();

    tb_done = 1'b1;
  end

endmodule
